// File: rtl/pll_reset_sequencer.sv
// Staged release of NUM_CH active-low resets once the PLL lock has been stable long enough.
// Latency: lock is 2 flops deep, all outputs registered; no backpressure, lock loss or force_rst aborts the sequence.
module pll_reset_sequencer #(
  parameter int NUM_CH         = 3,
  parameter int STABLE_CYCLES  = 1024,
  parameter int STAGGER_CYCLES = 16
) (
  input  logic              clock_in,
  input  logic              resetn,
  input  logic              locked,
  input  logic              force_rst,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              ready,
  output logic [7:0]        loss_count,
  output logic [1:0]        state_o
);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] STABILISE = 2'd1;
  localparam logic [1:0] RELEASE   = 2'd2;
  localparam logic [1:0] RUN       = 2'd3;

  localparam int SW  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int SGW = (STAGGER_CYCLES > 2) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [SW-1:0]     STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SGW-1:0]    STG_LAST  = SGW'(STAGGER_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ALL_ONES  = '1;
  // Pattern just before the top channel is released.
  localparam logic [NUM_CH-1:0] ALMOST    = ALL_ONES >> 1;

  logic [1:0]     state;
  logic           sync_q;
  logic           lock_s;
  logic [SW-1:0]  stable_cnt;
  logic [SGW-1:0] stagger_cnt;
  logic           lost;

  assign state_o = state;
  assign lost    = ((state == RELEASE) || (state == RUN)) && !lock_s;

  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      sync_q      <= 1'b0;
      lock_s      <= 1'b0;
      state       <= WAIT_LOCK;
      rst_n_out   <= '0;
      ready       <= 1'b0;
      loss_count  <= 8'd0;
      stable_cnt  <= '0;
      stagger_cnt <= '0;
    end else begin
      sync_q <= locked;
      lock_s <= sync_q;
      if (force_rst || lost) begin
        state       <= WAIT_LOCK;
        rst_n_out   <= '0;
        ready       <= 1'b0;
        stable_cnt  <= '0;
        stagger_cnt <= '0;
        // Only a real lock loss counts, even when force_rst coincides with it.
        if (lost && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
      end else begin
        case (state)
          WAIT_LOCK: begin
            if (lock_s) begin
              state      <= STABILISE;
              stable_cnt <= '0;
            end
          end
          STABILISE: begin
            if (!lock_s) begin
              state <= WAIT_LOCK;
            end else if (stable_cnt == STAB_LAST) begin
              state       <= RELEASE;
              rst_n_out   <= NUM_CH'(1);
              stagger_cnt <= '0;
              // A single channel is fully released in the first RELEASE cycle.
              ready       <= (NUM_CH == 1);
            end else begin
              stable_cnt <= stable_cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (NUM_CH == 1) begin
              state <= RUN;
            end else if (stagger_cnt == STG_LAST) begin
              stagger_cnt <= '0;
              rst_n_out   <= NUM_CH'({rst_n_out, 1'b1});
              if (rst_n_out == ALMOST) begin
                state <= RUN;
                ready <= 1'b1;
              end
            end else begin
              stagger_cnt <= stagger_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench: default instance for sequencing/loss/force, minimal instance for saturation and reset.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       resetn_a, locked_a, force_a;
  logic [2:0] rst_a;
  logic       ready_a;
  logic [7:0] loss_a;
  logic [1:0] state_a;

  logic       resetn_b, locked_b, force_b;
  logic [0:0] rst_b;
  logic       ready_b;
  logic [7:0] loss_b;
  logic [1:0] state_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer dut_a (
    .clock_in(clk), .resetn(resetn_a), .locked(locked_a), .force_rst(force_a),
    .rst_n_out(rst_a), .ready(ready_a), .loss_count(loss_a), .state_o(state_a)
  );

  pll_reset_sequencer #(.NUM_CH(1), .STABLE_CYCLES(2), .STAGGER_CYCLES(1)) dut_b (
    .clock_in(clk), .resetn(resetn_b), .locked(locked_b), .force_rst(force_b),
    .rst_n_out(rst_b), .ready(ready_b), .loss_count(loss_b), .state_o(state_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {state, ready, rst} of instance A.
  function automatic logic [31:0] va();
    return {26'd0, state_a, ready_a, rst_a};
  endfunction

  function automatic logic [31:0] vb();
    return {28'd0, state_b, ready_b, rst_b};
  endfunction

  initial begin
    resetn_a = 1'b0; locked_a = 1'b0; force_a = 1'b0;
    resetn_b = 1'b0; locked_b = 1'b0; force_b = 1'b0;
    tick(3);
    chk("a_reset_outs", va(), 32'h00);
    chk("a_reset_loss", {24'd0, loss_a}, 32'd0);
    chk("b_reset_outs", vb(), 32'h0);

    // Full default sequence, lock present from reset release.
    resetn_a = 1'b1; locked_a = 1'b1;
    tick(2);    chk("a_sync_wait", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    tick(1);    chk("a_enter_stab", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1023); chk("a_stab_last", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1);    chk("a_bit0_1027", va(), {26'd0, 2'd2, 1'b0, 3'b001});
    tick(15);   chk("a_bit1_early", va(), {26'd0, 2'd2, 1'b0, 3'b001});
    tick(1);    chk("a_bit1_16", va(), {26'd0, 2'd2, 1'b0, 3'b011});
    tick(15);   chk("a_bit2_early", va(), {26'd0, 2'd2, 1'b0, 3'b011});
    tick(1);    chk("a_run_32", va(), {26'd0, 2'd3, 1'b1, 3'b111});

    // Lock loss in RUN.
    locked_a = 1'b0;
    tick(2);    chk("a_loss_pending", va(), {26'd0, 2'd3, 1'b1, 3'b111});
    tick(1);    chk("a_loss_drop", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    chk("a_loss_cnt1", {24'd0, loss_a}, 32'd1);
    locked_a = 1'b1;
    tick(2);    chk("a_relock_wait", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    tick(1);    chk("a_relock_stab", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1024); chk("a_relock_rel", va(), {26'd0, 2'd2, 1'b0, 3'b001});
    tick(32);   chk("a_relock_run", va(), {26'd0, 2'd3, 1'b1, 3'b111});

    // force_rst from RUN, then a one-cycle lock glitch during STABILISE.
    force_a = 1'b1; tick(1); force_a = 1'b0;
    chk("a_force_run", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    chk("a_force_loss", {24'd0, loss_a}, 32'd1);
    tick(1);    chk("a_force_stab", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(100);
    locked_a = 1'b0; tick(1); locked_a = 1'b1;
    tick(2);    chk("a_glitch_wait", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    chk("a_glitch_loss", {24'd0, loss_a}, 32'd1);
    tick(1);    chk("a_glitch_stab", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1023); chk("a_glitch_full", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1);    chk("a_glitch_rel", va(), {26'd0, 2'd2, 1'b0, 3'b001});

    // force_rst in RELEASE after bit 0.
    tick(5);
    force_a = 1'b1; tick(1); force_a = 1'b0;
    chk("a_force_rel", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    chk("a_force_rel_loss", {24'd0, loss_a}, 32'd1);
    tick(1);    chk("a_restart_stab", va(), {26'd0, 2'd1, 1'b0, 3'b000});
    tick(1024); chk("a_restart_rel", va(), {26'd0, 2'd2, 1'b0, 3'b001});
    tick(32);   chk("a_restart_run", va(), {26'd0, 2'd3, 1'b1, 3'b111});

    // force_rst coinciding with lock loss counts once.
    locked_a = 1'b0;
    tick(2);
    force_a = 1'b1; tick(1); force_a = 1'b0;
    chk("a_both_outs", va(), {26'd0, 2'd0, 1'b0, 3'b000});
    chk("a_both_loss", {24'd0, loss_a}, 32'd2);

    // Minimal configuration.
    resetn_b = 1'b1; locked_b = 1'b1;
    tick(2);    chk("b_sync_wait", vb(), {28'd0, 2'd0, 1'b0, 1'b0});
    tick(1);    chk("b_stab0", vb(), {28'd0, 2'd1, 1'b0, 1'b0});
    tick(1);    chk("b_stab1", vb(), {28'd0, 2'd1, 1'b0, 1'b0});
    tick(1);    chk("b_release", vb(), {28'd0, 2'd2, 1'b1, 1'b1});
    tick(1);    chk("b_run", vb(), {28'd0, 2'd3, 1'b1, 1'b1});
    tick(5);    chk("b_run_hold", vb(), {28'd0, 2'd3, 1'b1, 1'b1});

    for (int i = 1; i <= 300; i++) begin
      locked_b = 1'b0;
      tick(3);
      if (i == 1 || i == 255 || i == 300) begin
        chk("b_loss_outs", vb(), {28'd0, 2'd0, 1'b0, 1'b0});
        chk("b_loss_cnt", {24'd0, loss_b}, (i > 255) ? 32'd255 : i);
      end
      locked_b = 1'b1;
      tick(6);
      if (i == 1 || i == 300) chk("b_loss_rerun", vb(), {28'd0, 2'd3, 1'b1, 1'b1});
    end
    chk("b_loss_sat", {24'd0, loss_b}, 32'd255);

    // Reset in RUN clears everything and restarts from lock sampling.
    resetn_b = 1'b0; tick(1);
    chk("b_rst_run_outs", vb(), 32'h0);
    chk("b_rst_run_loss", {24'd0, loss_b}, 32'd0);
    tick(1);
    resetn_b = 1'b1;
    tick(2);    chk("b_rst_resync", vb(), {28'd0, 2'd0, 1'b0, 1'b0});
    tick(1);    chk("b_rst_stab", vb(), {28'd0, 2'd1, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
